mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port req_i  in  1  access request from core, sampled only in IDLE.
REQ-004 SHALL have port MemRead_i  in  1  load request.
REQ-005 SHALL have port MemWrite_i  in  1  store request.
REQ-006 SHALL have port MemNum_i  in  2  size: 01 byte, 10 half, 11 word, 00 illegal.
REQ-007 SHALL have port UnSigned_i  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-008 SHALL have port addr_i  in  32  byte address.
REQ-009 SHALL have port wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port busy_o  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  out  1  one-cycle pulse, with done_o, on illegal or misaligned request.
REQ-013 SHALL have port rdata_o  out  32  extended load result.
REQ-014 SHALL have port mem_req_o  out  1  byte-memory request.
REQ-015 SHALL have port mem_we_o  out  1  byte-memory write enable.
REQ-016 SHALL have port mem_addr_o  out  32  byte-memory address.
REQ-017 SHALL have port mem_wdata_o  out  8  byte-memory write data.
REQ-018 SHALL have port mem_rdata_i  in  8  byte-memory read data, valid with mem_ack_i.
REQ-019 SHALL have port mem_ack_i  in  1  byte-memory acknowledge.

Function
REQ-020 SHALL implement FSM states IDLE, XFER, FIN; only IDLE accepts requests.
REQ-021 SHALL accept when req_i=1 in IDLE; latch addr, wdata, size, UnSigned, direction; req_i outside IDLE ignored.
REQ-022 SHALL flag illegal when MemRead_i==MemWrite_i or MemNum_i=00; flag misaligned when half has addr[0]=1 or word has addr[1:0]!=00.
REQ-023 SHALL, on illegal/misaligned accept, go IDLE->FIN with no mem_req_o assertion; FIN pulses done_o=1 and err_o=1; rdata_o unchanged.
REQ-024 SHALL, on legal accept, go IDLE->XFER with byte count N=1/2/4 and byte index k=0.
REQ-025 SHALL use big-endian order: byte k at mem_addr_o=addr+k, carrying data bits [8*(N-1-k)+7 : 8*(N-1-k)].
REQ-026 SHALL, in XFER, drive mem_req_o=1 with mem_addr_o/mem_we_o/mem_wdata_o stable until mem_ack_i=1 is sampled.
REQ-027 SHALL, on ack with k<N-1, increment k and present the next byte in the following cycle with mem_req_o still 1 (back-to-back).
REQ-028 SHALL, on ack with k=N-1, go XFER->FIN; mem_req_o=0 in FIN.
REQ-029 SHALL capture mem_rdata_i on each acknowledged read byte into a shift register (first byte most significant).
REQ-030 SHALL, in FIN after a legal read, load rdata_o with the result: byte sign/zero-extended from bit 7, half from bit 15, word unchanged; rdata_o holds until next successful read.
REQ-031 SHALL, in FIN, pulse done_o=1 for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after FIN.
REQ-032 SHALL ignore mem_ack_i while mem_req_o=0.
REQ-033 SHALL have latency, with mem_ack_i tied high, of N+1 cycles from accept edge to done_o (byte 2, half 3, word 5).
REQ-034 SHALL hold mem_wdata_o=0 and mem_we_o=0 during reads, and mem_we_o=0 outside XFER.
REQ-035 SHALL tolerate unbounded ack wait; no timeout.

Reset
REQ-036 SHALL, on rst_i=1, immediately (asynchronously) force IDLE, k=0, busy_o=0, done_o=0, err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0.
REQ-037 SHALL abort an in-progress transfer on reset mid-operation with no done_o pulse; bytes already written remain written.

Verification
REQ-038 SHALL test LB addr=0x103, memory byte 0x80, ack tied high -> one mem_req_o at 0x103, done_o 2 cycles after accept, rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SHALL test SW addr=0x200, wdata=0x11223344 -> writes 0x11@0x200, 0x22@0x201, 0x33@0x202, 0x44@0x203 on 4 consecutive cycles, done_o at cycle 5.
REQ-040 SHALL test LH addr=0x10, bytes 0x9A,0xBC, ack delayed 3 cycles per byte -> address/we stable while waiting, rdata_o=0xFFFF9ABC.
REQ-041 SHALL test LW addr=0x102 and MemRead_i=MemWrite_i=1 -> no mem_req_o, done_o=err_o=1 one cycle after accept, rdata_o unchanged.
REQ-042 SHALL test rst_i asserted after second byte of SW 0x300 -> mem_req_o drops same cycle, no done_o, next LW 0x300 accepted normally.
REQ-043 SHALL test req_i held high continuously -> back-to-back accesses each separated by FIN; req_i during XFER never restarts transfer.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and byte-memory bus of the memory access unit.
interface mem_access_unit_if;
  logic        req_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [1:0]  MemNum_i;
  logic        UnSigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  req_i, MemRead_i, MemWrite_i, MemNum_i, UnSigned_i, addr_i, wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output busy_o, done_o, err_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, MemRead_i, MemWrite_i, MemNum_i, UnSigned_i, addr_i, wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  busy_o, done_o, err_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Splits byte/half/word loads and stores into big-endian byte transfers on a
// byte-wide memory port; loads are reassembled and sign/zero-extended.
module mem_access_unit (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [1:0]      r_idx, w_idx;
  logic [1:0]      r_last, w_last;
  logic            r_we, w_we;
  logic            r_uns, w_uns;
  logic [DW-1:0]   r_wbuf, w_wbuf;
  logic [DW-1:0]   r_rbuf, w_rbuf;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_err, w_err;
  logic [DW-1:0]   r_rdata, w_rdata;
  logic            r_mem_req, w_mem_req;
  logic            r_mem_we, w_mem_we;
  logic [AW-1:0]   r_mem_addr, w_mem_addr;
  logic [BW-1:0]   r_mem_wdata, w_mem_wdata;

  logic            w_bad;
  logic [1:0]      w_req_last;
  logic [DW-1:0]   w_req_wbuf;
  logic            w_sx;

  // Illegal direction/size or misaligned half/word is rejected at accept.
  assign w_bad = (bus.MemRead_i == bus.MemWrite_i)
               | (bus.MemNum_i == 2'b00)
               | ((bus.MemNum_i == 2'b10) & bus.addr_i[0])
               | ((bus.MemNum_i == 2'b11) & (bus.addr_i[1:0] != 2'b00));

  // Store data is left-justified so the next byte to send is always [31:24].
  always_comb begin
    w_req_last = 2'd3;
    w_req_wbuf = bus.wdata_i;
    case (bus.MemNum_i)
      2'b01: begin
        w_req_last = 2'd0;
        w_req_wbuf = {bus.wdata_i[7:0], 24'h0};
      end
      2'b10: begin
        w_req_last = 2'd1;
        w_req_wbuf = {bus.wdata_i[15:0], 16'h0};
      end
      default: begin
        w_req_last = 2'd3;
        w_req_wbuf = bus.wdata_i;
      end
    endcase
    if (!bus.MemWrite_i) w_req_wbuf = '0;
  end

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_last      = r_last;
    w_we        = r_we;
    w_uns       = r_uns;
    w_wbuf      = r_wbuf;
    w_rbuf      = r_rbuf;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_rdata     = r_rdata;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_sx        = ~r_uns;

    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          if (w_bad) begin
            w_state = S_FIN;
            w_done  = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_state     = S_XFER;
            w_idx       = 2'd0;
            w_last      = w_req_last;
            w_we        = bus.MemWrite_i;
            w_uns       = bus.UnSigned_i;
            w_wbuf      = w_req_wbuf;
            w_rbuf      = '0;
            w_mem_req   = 1'b1;
            w_mem_we    = bus.MemWrite_i;
            w_mem_addr  = bus.addr_i;
            w_mem_wdata = w_req_wbuf[DW-1 -: BW];
          end
        end
      end

      S_XFER: begin
        if (bus.mem_ack_i) begin
          w_rbuf = {r_rbuf[DW-BW-1:0], bus.mem_rdata_i};
          if (r_idx == r_last) begin
            w_state     = S_FIN;
            w_done      = 1'b1;
            w_mem_req   = 1'b0;
            w_mem_we    = 1'b0;
            w_mem_wdata = '0;
            if (!r_we) begin
              case (r_last)
                2'd0:    w_rdata = {{24{w_sx & w_rbuf[7]}},  w_rbuf[7:0]};
                2'd1:    w_rdata = {{16{w_sx & w_rbuf[15]}}, w_rbuf[15:0]};
                default: w_rdata = w_rbuf;
              endcase
            end
          end else begin
            w_idx       = r_idx + 2'd1;
            w_wbuf      = {r_wbuf[DW-BW-1:0], 8'h00};
            w_mem_addr  = r_mem_addr + 32'd1;
            w_mem_wdata = w_wbuf[DW-1 -: BW];
          end
        end
      end

      S_FIN: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state   = S_IDLE;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_wbuf      <= '0;
      r_rbuf      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_last      <= w_last;
      r_we        <= w_we;
      r_uns       <= w_uns;
      r_wbuf      <= w_wbuf;
      r_rbuf      <= w_rbuf;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_rdata     <= w_rdata;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.rdata_o     = r_rdata;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-memory responder, vector table, directed
// corner sequences and randomized ops against a byte-level reference model.
module tb_mem_access_unit;

  logic clk;
  logic rst;

  mem_access_unit_if intf();

  mem_access_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (intf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
  } xfer_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  num;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nx;
  } vec_t;

  logic [7:0] mem [int unsigned];
  xfer_t      xlog [$];
  int         ack_mode  = 0;
  int         fix_delay = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'(a * 32'd5 + 32'h3C);
  endfunction

  function automatic int nbytes(input logic [1:0] num);
    if (num == 2'b01) return 1;
    if (num == 2'b10) return 2;
    return 4;
  endfunction

  function automatic bit is_bad(input logic rd, input logic wr, input logic [1:0] num,
                                input logic [31:0] a);
    return (rd == wr) || (num == 2'b00) || (num == 2'b10 && a[0]) ||
           (num == 2'b11 && a[1:0] != 2'b00);
  endfunction

  // Big-endian assemble of the addressed bytes, then extend to 32 bits.
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] num,
                                             input logic uns);
    longint unsigned v = 0;
    int n = nbytes(num);
    for (int k = 0; k < n; k++) v = v * 256 + longint'(mem_rd(a + 32'(k)));
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  task automatic check_xfers(input string tag, input logic rd, input logic wr,
                             input logic [1:0] num, input logic [31:0] a, input logic [31:0] wd);
    int n = is_bad(rd, wr, num, a) ? 0 : nbytes(num);
    check({tag, "_nxfer"}, 32'(xlog.size()), 32'(n));
    if (xlog.size() == n) begin
      for (int k = 0; k < n; k++) begin
        check({tag, "_addr"}, xlog[k].addr, a + 32'(k));
        check({tag, "_we"}, 32'(xlog[k].we), 32'(wr));
        if (wr) check({tag, "_wdata"}, 32'(xlog[k].data), (wd >> (8 * (n - 1 - k))) & 32'hFF);
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns latency in cycles after accept.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] num, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rdata, output int lat,
                        output logic done_next);
    xlog.delete();
    intf.MemRead_i  = rd;
    intf.MemWrite_i = wr;
    intf.MemNum_i   = num;
    intf.UnSigned_i = uns;
    intf.addr_i     = a;
    intf.wdata_i    = wd;
    intf.req_i      = 1'b1;
    lat = 0; err = 1'b0; rdata = 32'h0; done_next = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      intf.req_i = 1'b0;
      if (intf.done_o) begin
        lat = c; err = intf.err_o; rdata = intf.rdata_o;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      done_next = intf.done_o;
    end
  endtask

  // Byte memory: acks after a per-byte delay, logs every acknowledged transfer.
  initial begin : responder
    int   wait_cnt = 0;
    int   cur_delay = 0;
    bit   need_delay = 1'b1;
    bit   prev_wait = 1'b0;
    logic [31:0] p_addr = '0;
    logic        p_we = 1'b0;
    logic [7:0]  p_wd = '0;
    intf.mem_ack_i   = 1'b0;
    intf.mem_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !intf.mem_req_o) begin
        if (!rst) begin
          check("we_outside_xfer", 32'(intf.mem_we_o), 32'h0);
          if (prev_wait) check("req_dropped_without_ack", 32'(intf.mem_req_o), 32'h1);
        end
        intf.mem_ack_i = (ack_mode == 0) ? 1'b1 : (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        intf.mem_rdata_i = 8'($urandom);
        wait_cnt = 0; need_delay = 1'b1; prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check("stable_addr", intf.mem_addr_o, p_addr);
          check("stable_we", 32'(intf.mem_we_o), 32'(p_we));
          check("stable_wdata", 32'(intf.mem_wdata_o), 32'(p_wd));
        end
        if (!intf.mem_we_o) check("read_wdata_zero", 32'(intf.mem_wdata_o), 32'h0);
        if (need_delay) begin
          cur_delay  = (ack_mode == 0) ? 0 : (ack_mode == 1) ? fix_delay : int'($urandom_range(0, 2));
          need_delay = 1'b0;
        end
        if (wait_cnt >= cur_delay) begin
          intf.mem_ack_i   = 1'b1;
          intf.mem_rdata_i = mem_rd(intf.mem_addr_o);
          xlog.push_back('{we: intf.mem_we_o, addr: intf.mem_addr_o, data: intf.mem_wdata_o});
          if (intf.mem_we_o) mem[intf.mem_addr_o] = intf.mem_wdata_o;
          wait_cnt = 0; need_delay = 1'b1; prev_wait = 1'b0;
        end else begin
          intf.mem_ack_i   = 1'b0;
          intf.mem_rdata_i = 8'($urandom);
          wait_cnt++;
          prev_wait = 1'b1;
          p_addr = intf.mem_addr_o; p_we = intf.mem_we_o; p_wd = intf.mem_wdata_o;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        vecs [16];
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        dn;

    vecs[0]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0,        1'b0, 32'hFFFFFF80, 2, 1};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h103, 32'h0,        1'b0, 32'h00000080, 2, 1};
    vecs[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h200, 32'h11223344, 1'b0, 32'h00000080, 5, 4};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0,        1'b0, 32'h11223344, 5, 4};
    vecs[4]  = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h102, 32'h0,        1'b1, 32'h11223344, 1, 0};
    vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h201, 32'h0,        1'b1, 32'h11223344, 1, 0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        1'b1, 32'h11223344, 1, 0};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h202, 32'h0,        1'b0, 32'h00003344, 3, 2};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h210, 32'hDEADBEA5, 1'b0, 32'h00003344, 2, 1};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h210, 32'h0,        1'b0, 32'hFFFFFFA5, 2, 1};
    vecs[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h212, 32'h00007F01, 1'b0, 32'hFFFFFFA5, 3, 2};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h212, 32'h0,        1'b0, 32'h00007F01, 3, 2};
    vecs[12] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h220, 32'h0,        1'b1, 32'h00007F01, 1, 0};
    vecs[13] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h301, 32'hCAFEF00D, 1'b1, 32'h00007F01, 1, 0};
    vecs[14] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h214, 32'h1234C0DE, 1'b0, 32'h00007F01, 3, 2};
    vecs[15] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h214, 32'h0,        1'b0, 32'hFFFFC0DE, 3, 2};

    mem[32'h103] = 8'h80;
    mem[32'h10]  = 8'h9A;
    mem[32'h11]  = 8'hBC;

    rst = 1'b1;
    intf.req_i = 1'b0; intf.MemRead_i = 1'b0; intf.MemWrite_i = 1'b0;
    intf.MemNum_i = 2'b00; intf.UnSigned_i = 1'b0; intf.addr_i = '0; intf.wdata_i = '0;
    #1;
    check("rst_busy", 32'(intf.busy_o), 32'h0);
    check("rst_done", 32'(intf.done_o), 32'h0);
    check("rst_err", 32'(intf.err_o), 32'h0);
    check("rst_rdata", intf.rdata_o, 32'h0);
    check("rst_mem_req", 32'(intf.mem_req_o), 32'h0);
    check("rst_mem_we", 32'(intf.mem_we_o), 32'h0);
    check("rst_mem_addr", intf.mem_addr_o, 32'h0);
    check("rst_mem_wdata", 32'(intf.mem_wdata_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Vector table with ack tied high.
    ack_mode = 0;
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].num, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             err, rdata, lat, dn);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_done_pulse", i), 32'(dn), 32'h0);
      check($sformatf("vec%0d_nx", i), 32'(xlog.size()), 32'(vecs[i].exp_nx));
      check_xfers($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].num,
                  vecs[i].addr, vecs[i].wdata);
    end
    model_rdata = vecs[15].exp_rdata;

    // Half load with every byte acknowledged three cycles late.
    ack_mode = 1; fix_delay = 3;
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, err, rdata, lat, dn);
    check("lh_slow_lat", 32'(lat), 32'd9);
    check("lh_slow_err", 32'(err), 32'h0);
    check("lh_slow_rdata", rdata, 32'hFFFF9ABC);
    check_xfers("lh_slow", 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    model_rdata = 32'hFFFF9ABC;

    // Reset after the second byte of a word store.
    ack_mode = 0;
    xlog.delete();
    intf.MemRead_i = 1'b0; intf.MemWrite_i = 1'b1; intf.MemNum_i = 2'b11;
    intf.UnSigned_i = 1'b0; intf.addr_i = 32'h300; intf.wdata_i = 32'hA1B2C3D4;
    intf.req_i = 1'b1;
    @(negedge clk);
    intf.req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_req_before", 32'(intf.mem_req_o), 32'h1);
    rst = 1'b1;
    #2;
    check("rst_mid_req_drop", 32'(intf.mem_req_o), 32'h0);
    check("rst_mid_busy", 32'(intf.busy_o), 32'h0);
    check("rst_mid_rdata", intf.rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(intf.done_o), 32'h0);
    end
    check("rst_mid_nwritten", 32'(xlog.size()), 32'd2);
    if (xlog.size() == 2) begin
      check("rst_mid_w0", {xlog[0].addr[23:0], xlog[0].data}, 32'h000300A1);
      check("rst_mid_w1", {xlog[1].addr[23:0], xlog[1].data}, 32'h000301B2);
    end
    run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h300, 32'h0, err, rdata, lat, dn);
    model_rdata = model_read(32'h300, 2'b11, 1'b0);
    check("lw_after_rst_lat", 32'(lat), 32'd5);
    check("lw_after_rst_err", 32'(err), 32'h0);
    check("lw_after_rst_rdata", rdata, model_rdata);
    check("lw_after_rst_hi", rdata & 32'hFFFF0000, 32'hA1B20000);

    // req_i held high: back-to-back word loads, each separated by FIN and IDLE.
    ack_mode = 2;
    begin
      int dones = 0;
      bit prev_done = 1'b0;
      bit ok = 1'b0;
      xlog.delete();
      intf.MemRead_i = 1'b1; intf.MemWrite_i = 1'b0; intf.MemNum_i = 2'b11;
      intf.UnSigned_i = 1'b0; intf.addr_i = 32'h400; intf.wdata_i = 32'h0;
      intf.req_i = 1'b1;
      model_rdata = model_read(32'h400, 2'b11, 1'b0);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (prev_done) begin
          check("held_idle_gap", 32'(intf.busy_o), 32'h0);
          if (dones == 3) begin
            ok = 1'b1;
            break;
          end
        end
        prev_done = intf.done_o;
        if (intf.done_o) begin
          dones++;
          check("held_err", 32'(intf.err_o), 32'h0);
          check("held_rdata", intf.rdata_o, model_rdata);
          if (dones == 3) intf.req_i = 1'b0;
        end
      end
      intf.req_i = 1'b0;
      check("held_completed", 32'(ok), 32'h1);
      check("held_nxfer", 32'(xlog.size()), 32'd12);
      if (xlog.size() == 12)
        for (int i = 0; i < 12; i++) check("held_addr", xlog[i].addr, 32'h400 + 32'(i % 4));
      @(negedge clk);
    end

    // Randomized ops with random ack delays and spurious idle acks.
    for (int t = 0; t < 40; t++) begin
      logic        rd, wr, uns;
      logic [1:0]  num;
      logic [31:0] a, wd;
      int          rw = int'($urandom_range(0, 7));
      rd  = (rw < 4) || (rw == 7);
      wr  = (rw >= 4 && rw < 7) || (rw == 7 && $urandom_range(0, 1) == 1);
      num = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = 32'h500 + 32'($urandom_range(0, 15));
      wd  = $urandom;
      run_op(rd, wr, num, uns, a, wd, err, rdata, lat, dn);
      if (!is_bad(rd, wr, num, a) && rd) model_rdata = model_read(a, num, uns);
      check("rnd_done_seen", 32'(lat != 0), 32'h1);
      check("rnd_err", 32'(err), 32'(is_bad(rd, wr, num, a)));
      check("rnd_rdata", rdata, model_rdata);
      check("rnd_done_pulse", 32'(dn), 32'h0);
      check_xfers("rnd", rd, wr, num, a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
